// File: rtl/disp_scan.sv
// disp_scan: six-digit multiplexed BCD display scanner with a double-buffered digit bank.
module disp_scan #(
  parameter int SCAN_DIV = 5000,
  parameter int BLANK_CYC = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Q5,
  input  logic [3:0] Q4,
  input  logic [3:0] Q3,
  input  logic [3:0] Q2,
  input  logic [3:0] Q1,
  input  logic [3:0] Q0,
  input  logic       latch_req,
  output logic [3:0] bcd_out,
  output logic [2:0] disp_select,
  output logic [5:0] digit_en,
  output logic       frame_tick,
  output logic       latch_pending
);
  typedef enum logic {BLANK, SHOW} state_t;
  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLK = 16'(BLANK_CYC);
  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [2:0] sel_nx;
  logic wrap, boundary;
  logic [3:0] q_in [6];
  logic [3:0] shadow [6];
  logic [3:0] disp [6];
  logic [3:0] disp_nx [6];
  // banks are indexed by slot, so slot 0 holds the most significant digit
  assign q_in = '{Q5, Q4, Q3, Q2, Q1, Q0};
  always_comb begin
    wrap = cnt == LAST;
    boundary = wrap && disp_select == 3'd5;
    cnt_nx = wrap ? '0 : cnt + 16'd1;
    sel_nx = !wrap ? disp_select : boundary ? 3'd0 : disp_select + 3'd1;
    state_nx = (wrap && BLK != '0) ? BLANK : (cnt_nx >= BLK) ? SHOW : state;
    disp_nx = (boundary && latch_pending) ? shadow : disp;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      disp_select <= '0;
      state <= BLANK;
      bcd_out <= '0;
      digit_en <= '0;
      frame_tick <= 1'b0;
      latch_pending <= 1'b0;
      shadow <= '{default: '0};
      disp <= '{default: '0};
    end else begin
      cnt <= cnt_nx;
      disp_select <= sel_nx;
      state <= state_nx;
      disp <= disp_nx;
      bcd_out <= disp_nx[sel_nx];
      digit_en <= (state_nx == SHOW) ? 6'b1 << sel_nx : '0;
      frame_tick <= boundary;
      if (latch_req) shadow <= q_in;
      latch_pending <= latch_req || (latch_pending && !boundary);
    end
  end
endmodule
